// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the instruction-cache address split.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = WORD_W - IIDX_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// Hits return data combinationally; a miss stalls in MISS until memory control drops iwait.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    input  logic  flush,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload,
    output logic  dbg_miss_o
);

    localparam int IW = $clog2(SETS);
    localparam int TW = WORD_W - IW - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t         state_q, state_d;
    word_t          miss_q, miss_d;
    logic [SETS-1:0] valid_q;
    logic [TW-1:0]  tag_q  [SETS];
    word_t          data_q [SETS];

    logic [TW-1:0]  req_tag;
    logic [IW-1:0]  req_idx;
    logic [TW-1:0]  miss_tag;
    logic [IW-1:0]  miss_idx;
    logic           fill;
    logic           unused_bytoff;

    assign req_tag       = imemaddr[WORD_W-1:IW+2];
    assign req_idx       = imemaddr[IW+1:2];
    assign miss_tag      = miss_q[WORD_W-1:IW+2];
    assign miss_idx      = miss_q[IW+1:2];
    assign unused_bytoff = ^imemaddr[1:0];
    assign dbg_miss_o    = (state_q == MISS);

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        fill     = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_idx];
                end else if (imemREN) begin
                    miss_d  = {imemaddr[WORD_W-1:2], 2'b00};
                    state_d = MISS;
                end
            end
            MISS: begin
                // The latched address owns the fill; the live fetch address is ignored here.
                iREN  = 1'b1;
                iaddr = miss_q;
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            // Flush beats a coincident fill: the frame is written but stays invalid.
            if (flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches against a frame-level model.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  imemREN;
    word_t imemaddr;
    logic  flush;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    logic  dbg_miss_o;

    int total = 0;
    int bad   = 0;

    // Model: what each of the 16 frames holds, keyed by index.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    word_t       m_data  [16];

    icache #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .dbg_miss_o(dbg_miss_o)
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_word(input word_t a);
        word_t w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h340100F0;
        return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_fill(input word_t a);
        m_valid[a[5:2]] = 1'b1;
        m_tag[a[5:2]]   = a[31:6];
        m_data[a[5:2]]  = mem_word(a);
    endtask

    function automatic bit model_hit(input word_t a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Full fetch: predict hit/miss, service a miss with lat wait cycles, then confirm the hit.
    task automatic do_fetch(input word_t a, input int lat);
        bit    exp_hit;
        word_t aligned;
        exp_hit  = model_hit(a);
        aligned  = {a[31:2], 2'b00};
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        @(negedge CLK);
        chk("first_ihit", word_t'(ihit), word_t'(exp_hit));
        chk("first_load", imemload, exp_hit ? m_data[a[5:2]] : 32'h0);
        chk("first_iren", word_t'(iREN), 32'h0);
        if (!exp_hit) begin
            step();
            for (int k = 0; k < lat; k++) begin
                @(negedge CLK);
                chk("wait_iren", word_t'(iREN), 32'h1);
                chk("wait_iaddr", iaddr, aligned);
                chk("wait_ihit", word_t'(ihit), 32'h0);
                step();
            end
            iwait = 1'b0;
            iload = mem_word(a);
            @(negedge CLK);
            chk("fill_iren", word_t'(iREN), 32'h1);
            chk("fill_iaddr", iaddr, aligned);
            step();
            iwait = 1'b1;
            iload = $urandom;
            model_fill(a);
            @(negedge CLK);
            chk("refetch_ihit", word_t'(ihit), 32'h1);
            chk("refetch_load", imemload, m_data[a[5:2]]);
            chk("refetch_iren", word_t'(iREN), 32'h0);
        end
        step();
    endtask

    task automatic do_flush();
        imemREN = 1'b0;
        flush   = 1'b1;
        @(negedge CLK);
        chk("flush_ihit", word_t'(ihit), 32'h0);
        chk("flush_load", imemload, 32'h0);
        step();
        flush = 1'b0;
        model_clear();
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
        model_clear();
        #12;
        chk("rst_ihit", word_t'(ihit), 32'h0);
        chk("rst_iren", word_t'(iREN), 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_load", imemload, 32'h0);
        chk("rst_state", word_t'(dbg_miss_o), 32'h0);
        step();
        nRST = 1'b1;
        step();

        // Cold miss, hit, conflict eviction and re-miss.
        do_fetch(32'h0, 2);
        do_fetch(32'h0, 0);
        do_fetch(32'h40, 1);
        do_fetch(32'h0, 0);

        // Flush invalidates a filled frame.
        do_fetch(32'h4, 1);
        do_flush();
        do_fetch(32'h4, 0);

        // Address and request change mid-miss must not redirect the fill.
        imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        step();
        imemaddr = 32'hC; imemREN = 1'b0;
        @(negedge CLK);
        chk("mid_state", word_t'(dbg_miss_o), 32'h1);
        chk("mid_iaddr", iaddr, 32'h8);
        step();
        iwait = 1'b0; iload = mem_word(32'h8);
        @(negedge CLK);
        chk("mid_fill_iaddr", iaddr, 32'h8);
        step();
        iwait = 1'b1;
        model_fill(32'h8);
        do_fetch(32'hC, 1);
        do_fetch(32'h8, 0);

        // Flush coinciding with fill completion leaves the frame invalid.
        imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
        step();
        iwait = 1'b0; iload = mem_word(32'h200); flush = 1'b1;
        step();
        iwait = 1'b1; flush = 1'b0; imemREN = 1'b0;
        model_clear();
        @(negedge CLK);
        chk("ff_state", word_t'(dbg_miss_o), 32'h0);
        chk("ff_iren", word_t'(iREN), 32'h0);
        step();
        do_fetch(32'h200, 0);

        // Reset during a miss abandons the fill.
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        step();
        @(negedge CLK);
        chk("prerst_iren", word_t'(iREN), 32'h1);
        nRST = 1'b0;
        #1;
        chk("rstmid_iren", word_t'(iREN), 32'h0);
        chk("rstmid_iaddr", iaddr, 32'h0);
        chk("rstmid_ihit", word_t'(ihit), 32'h0);
        imemREN = 1'b0;
        model_clear();
        step();
        nRST = 1'b1;
        step();
        do_fetch(32'h100, 1);

        // Random fetches over a small tag/index pool to force conflicts and reuse.
        for (int n = 0; n < 150; n++) begin
            word_t a;
            a = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, 15)) << 2)
                | word_t'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) do_flush();
            do_fetch(a, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter: SETS, 16, number of direct-mapped one-word frames (power of two, index width IIDX_W = log2(SETS)).
REQ-002 SHALL have port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imemREN  input  1  datapath instruction fetch request.
REQ-005 SHALL have port: imemaddr  input  32  fetch byte address (word aligned, bits[1:0] ignored).
REQ-006 SHALL have port: flush  input  1  invalidate all frames.
REQ-007 SHALL have port: ihit  output  1  fetch data valid this cycle.
REQ-008 SHALL have port: imemload  output  32  fetched instruction word.
REQ-009 SHALL have port: iREN  output  1  read request to memory control.
REQ-010 SHALL have port: iaddr  output  32  read address to memory control.
REQ-011 SHALL have port: iwait  input  1  memory control busy; low = iload valid.
REQ-012 SHALL have port: iload  input  32  word returned by memory control.

Function
REQ-013 SHALL split address as tag = imemaddr[31:IIDX_W+2], index = imemaddr[IIDX_W+1:2], byte offset = imemaddr[1:0].
REQ-014 SHALL store per frame: valid bit, tag, 32-bit data word.
REQ-015 SHALL implement two states: IDLE, MISS.
REQ-016 In IDLE, ihit SHALL be combinational: imemREN & valid[index] & (tag[index] == tag), imemload = data[index]; zero-cycle hit latency.
REQ-017 In IDLE, imemREN with no hit SHALL latch imemaddr into a miss-address register and transition to MISS on the next edge; ihit = 0 that cycle.
REQ-018 In MISS, iREN SHALL be 1 and iaddr SHALL equal the latched miss address (word aligned); ihit = 0.
REQ-019 In MISS, on an edge where iwait = 0, frame[latched index] SHALL be written with iload, latched tag, valid = 1, and state SHALL return to IDLE.
REQ-020 After a fill, the next IDLE cycle SHALL re-evaluate the current imemaddr; same address yields ihit = 1 with the filled word (miss penalty = memory latency + 1 cycle).
REQ-021 imemREN deasserting or imemaddr changing during MISS SHALL NOT abort the fill; the fill completes to the latched index.
REQ-022 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-023 flush SHALL clear all valid bits on the next edge, in any state; data and tags are left unchanged.
REQ-024 flush coinciding with fill completion SHALL leave the filled frame invalid (flush wins); state still returns to IDLE.
REQ-025 A conflicting tag at an occupied index SHALL replace the frame (no write-back; instruction cache is read-only).
REQ-026 imemload SHALL be 0 whenever ihit = 0.

Reset
REQ-027 nRST low SHALL immediately force state IDLE, all valid bits 0, miss-address register 0, so ihit = 0, iREN = 0, iaddr = 0, imemload = 0.
REQ-028 Reset asserted during MISS SHALL abandon the fill; no frame is written.
REQ-029 Tag and data arrays need not be reset.

Structure
REQ-030 word_t, ITAG_W, IIDX_W and the icachef_t packed struct (tag, idx, bytoff) SHALL live in cpu_types_pkg; the state enum is local to icache.
REQ-031 SHALL be a single module with no sub-modules; connects to memory control through the caches interface signal set listed above.

Verification
REQ-032 Cold miss: reset, imemREN = 1, imemaddr = 0x0 -> iREN = 1, iaddr = 0x0 next cycle; after iwait drops with iload = 0x340100F0, next cycle ihit = 1, imemload = 0x340100F0.
REQ-033 Hit: repeat fetch of 0x0 -> ihit = 1 same cycle, iREN stays 0.
REQ-034 Conflict: fetch 0x40 (index 0, tag 1) after 0x0 -> miss, iaddr = 0x40; then fetch 0x0 -> miss again.
REQ-035 Flush: after filling 0x4, pulse flush one cycle -> fetch of 0x4 misses, iREN = 1.
REQ-036 Address change mid-miss: miss on 0x8, change imemaddr to 0xC while iwait = 1 -> iaddr stays 0x8, frame 2 filled, then miss on 0xC.
REQ-037 Reset mid-miss: assert nRST = 0 while iREN = 1 -> iREN = 0 immediately; fetch of same address afterwards misses.
